div: RTL
========

Name: div

Overview:
- Multi-cycle 32-bit radix-2 restoring divider; the responder end of the EX stage's divide handshake for DIV and DIVU.
- EX drives the operands, the signed flag and start, and holds them until ready. The divider returns {remainder, quotient}, which EX writes to {HI, LO}.
- One quotient bit per cycle; the pipeline stalls on stallreq_from_ex until the result returns.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH. Only 32 is required to be supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; rst=0 forces reset immediately, independent of clk.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled in FREE when start is accepted.
- opdata1_i  in  32  dividend; sampled in FREE when start is accepted.
- opdata2_i  in  32  divisor; sampled in FREE when start is accepted.
- start_i  in  1  request; EX holds it high until it sees ready_o=1, then drops it in the same cycle.
- annul_i  in  1  pipeline flush; abandons any operation in progress.
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, cnt=0, internal registers=0, result_o=0, ready_o=0.
- result_o and ready_o are registered outputs.
- State FREE:
  - start_i=1, annul_i=0, opdata2_i!=0: go to ON, cnt<=0.
  - On that transition, latch the operand magnitudes:
    - dividend magnitude = two's-complement negation if signed_div_i=1 and bit31=1, else the raw value.
    - divisor magnitude = same rule.
  - Also on that transition, latch the quotient sign (opdata1_i[31]^opdata2_i[31], gated by signed_div_i) and the remainder sign (opdata1_i[31], gated by signed_div_i).
  - start_i=1, annul_i=0, opdata2_i==0: go to BY_ZERO.
  - Otherwise: stay in FREE; ready_o=0, result_o=0.
- State BY_ZERO: next edge goes to END with the raw result forced to 0.
- State ON (one iteration per cycle, cnt 0..31):
  - 65-bit working register W = {rem[32:0], quo[31:0]}, initialised to {33'b0, |dividend|}.
  - Each cycle, shift W left by 1, then form t = W[64:32] - {1'b0, |divisor|}.
  - If t is non-negative: W[64:32]<=t and W[0]<=1; otherwise W[0]<=0.
  - cnt increments each cycle. At cnt==31, after the final iteration, go to END.
  - annul_i=1 or start_i=0: abort to FREE immediately at that edge; result_o=0, ready_o=0. annul_i takes priority over every other input.
- State END:
  - Each edge loads result_o with the corrected result and sets ready_o=1.
  - Quotient is negated if the quotient sign=1; remainder is negated if the remainder sign=1.
  - start_i=0 or annul_i=1: go to FREE, ready_o<=0, result_o<=0.
- Latency:
  - Start accepted at edge E0: iterations at E1..E32; ready_o=1 and result_o valid after E33.
  - Because EX drops start_i on seeing ready, ready_o is high for exactly one cycle (cleared at E34).
  - Divide-by-zero: ready_o=1 after E2, with result_o=0.
- Boundaries:
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0; no trap.
  - Unsigned 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
  - A dividend smaller than the divisor gives quotient 0 and remainder = dividend.
  - Operand changes after acceptance are ignored.
  - A new start_i is not accepted until the block is back in FREE. The earliest new operation is accepted at the edge after the return to FREE.
  - Reset asserted in any state returns to FREE with all outputs 0 at once; no partial result escapes.

Test Plan:
- Unsigned 100/7, start held until ready -> ready_o rises 33 cycles after acceptance; result_o=0x00000002_0000000E; ready_o back to 0 on the next edge after start drops.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero (signed or unsigned, dividend 0x1234) -> ready_o rises 2 cycles after acceptance; result_o=0.
- Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000. Unsigned 0xFFFFFFFF/0x10 -> 0x0000000F_0FFFFFFF.
- annul_i pulsed for 1 cycle at iteration cnt=10 -> returns to FREE, ready_o stays 0. A following unsigned 50/5 then gives 0x00000000_0000000A with full latency.
- rst driven low asynchronously (between clock edges) at iteration 20 -> ready_o=0 and result_o=0 at once. After release, a new unsigned 9/4 -> 0x00000001_00000002.

Source files
------------

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient}; one quotient bit per cycle.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [2*WIDTH:0] w_q;
  logic [WIDTH-1:0] divisor_q;
  logic             quo_neg_q, rem_neg_q;

  logic             accept, abort;
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [2*WIDTH:0] w_shift, w_step;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes and sign bookkeeping for the signed case
  always_comb begin
    accept       = start_i & ~annul_i;
    abort        = annul_i | ~start_i;
    op1_neg      = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg      = signed_div_i & opdata2_i[WIDTH-1];
    dividend_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    divisor_mag  = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // One restoring step: keep the subtraction only when it does not go negative
  always_comb begin
    w_shift = w_q << 1;
    diff    = w_shift[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    if (diff[WIDTH])
      w_step = {w_shift[2*WIDTH:1], 1'b0};
    else
      w_step = {diff, w_shift[WIDTH-1:1], 1'b1};
    quo_fix = quo_neg_q ? (~w_q[WIDTH-1:0] + 1'b1) : w_q[WIDTH-1:0];
    rem_fix = rem_neg_q ? (~w_q[2*WIDTH-1:WIDTH] + 1'b1) : w_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (accept)
          state_d = (opdata2_i == '0) ? BY_ZERO : ON;
      end
      BY_ZERO: state_d = annul_i ? FREE : END;
      ON: begin
        if (abort)
          state_d = FREE;
        else if (cnt_q == LAST_CNT)
          state_d = END;
      end
      END: begin
        if (abort)
          state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= FREE;
    else
      state_q <= state_d;
  end

  // Datapath and registered outputs; anything but a live END holds outputs at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      w_q       <= '0;
      divisor_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (accept) begin
            cnt_q     <= '0;
            w_q       <= {{(WIDTH+1){1'b0}}, dividend_mag};
            divisor_q <= divisor_mag;
            quo_neg_q <= op1_neg ^ op2_neg;
            rem_neg_q <= op1_neg;
          end
        end
        BY_ZERO: begin
          w_q       <= '0;
          quo_neg_q <= 1'b0;
          rem_neg_q <= 1'b0;
          result_o  <= '0;
          ready_o   <= 1'b0;
        end
        ON: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (!abort) begin
            w_q   <= w_step;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        END: begin
          if (abort) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
